rst_req_ctrl: RTL and testbench

RST_REQ_CTRL -- requirements
Module: rst_req_ctrl

---
 rtl/rst_req_ctrl.sv | 147 ++++++++++++++
 tb/tb_rst_req_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rst_req_ctrl.sv
// Reset request controller: turns sw, PLL lock-loss and watchdog events into a
// fixed-width active-low reset request followed by a cool-down lockout.
module rst_req_ctrl #(
  parameter int unsigned ASSERT_CYC = 16,
  parameter int unsigned COOL_CYC   = 64,
  parameter int unsigned WDT_CYC    = 1024,
  parameter int unsigned LOCK_FILT  = 4
) (
  input  logic       src_clk,
  input  logic       arstn,
  input  logic       sw_rst_req,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  input  logic       pll_locked,
  output logic       rst_req_n,
  output logic [1:0] rst_cause,
  output logic       busy,
  output logic [7:0] rst_cnt
);

  localparam int unsigned MAX_CYC = (ASSERT_CYC > COOL_CYC) ? ASSERT_CYC : COOL_CYC;
  localparam int unsigned TMR_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
  localparam int unsigned WDT_W   = ($clog2(WDT_CYC) < 1) ? 1 : $clog2(WDT_CYC);
  localparam int unsigned FILT_W  = ($clog2(LOCK_FILT) < 1) ? 1 : $clog2(LOCK_FILT);

  localparam logic [TMR_W-1:0]  ASSERT_LOAD = TMR_W'(ASSERT_CYC - 1);
  localparam logic [TMR_W-1:0]  COOL_LOAD   = TMR_W'(COOL_CYC - 1);
  localparam logic [WDT_W-1:0]  WDT_LAST    = WDT_W'(WDT_CYC - 1);
  localparam logic [FILT_W-1:0] FILT_LAST   = FILT_W'(LOCK_FILT - 1);

  typedef enum logic [1:0] {IDLE, ASSERT, COOL} state_t;

  state_t            state, state_nx;
  logic [TMR_W-1:0]  tmr, tmr_nx;
  logic [1:0]        rst_sync;
  logic [1:0]        pll_sync;
  logic              run;
  logic              pll_s;
  logic              armed;
  logic [FILT_W-1:0] low_cnt;
  logic              pll_fail;
  logic [WDT_W-1:0]  wdt_cnt;
  logic              wdt_fail_c;
  logic              pending_sw;
  logic              start_c;
  logic [1:0]        cause_c;

  assign run   = rst_sync[1];
  assign pll_s = pll_sync[1];

  // Reset release and PLL lock both cross into src_clk through two flops.
  always_ff @(posedge src_clk or negedge arstn) begin
    if (!arstn) begin
      rst_sync <= 2'b00;
      pll_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
      pll_sync <= {pll_sync[0], pll_locked};
    end
  end

  // Lock-loss filter: armed by a high lock, fires after LOCK_FILT low cycles.
  always_ff @(posedge src_clk or negedge arstn) begin
    if (!arstn) begin
      armed    <= 1'b0;
      low_cnt  <= '0;
      pll_fail <= 1'b0;
    end else begin
      pll_fail <= armed && !pll_s && (low_cnt == FILT_LAST);
      if (!armed || pll_s || (low_cnt == FILT_LAST)) low_cnt <= '0;
      else                                          low_cnt <= low_cnt + FILT_W'(1);
      if (start_c)    armed <= 1'b0;
      else if (pll_s) armed <= 1'b1;
    end
  end

  assign wdt_fail_c = (state == IDLE) && wdt_en && (wdt_cnt == WDT_LAST);

  always_ff @(posedge src_clk or negedge arstn) begin
    if (!arstn) begin
      wdt_cnt <= '0;
    end else if ((state != IDLE) || !run || !wdt_en || wdt_kick || wdt_fail_c) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end

  // A software request while busy is remembered until the lockout ends.
  always_ff @(posedge src_clk or negedge arstn) begin
    if (!arstn)                               pending_sw <= 1'b0;
    else if (start_c)                         pending_sw <= 1'b0;
    else if ((state != IDLE) && sw_rst_req)   pending_sw <= 1'b1;
  end

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    start_c  = 1'b0;
    cause_c  = 2'b11;
    if (sw_rst_req || pending_sw) cause_c = 2'b01;
    else if (pll_fail)            cause_c = 2'b10;
    case (state)
      IDLE: begin
        if (run && (sw_rst_req || pending_sw || pll_fail || wdt_fail_c)) begin
          state_nx = ASSERT;
          tmr_nx   = ASSERT_LOAD;
          start_c  = 1'b1;
        end
      end
      ASSERT: begin
        if (tmr == '0) begin
          state_nx = COOL;
          tmr_nx   = COOL_LOAD;
        end else begin
          tmr_nx = tmr - TMR_W'(1);
        end
      end
      COOL: begin
        if (tmr == '0) state_nx = IDLE;
        else           tmr_nx   = tmr - TMR_W'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge src_clk or negedge arstn) begin
    if (!arstn) begin
      state     <= IDLE;
      tmr       <= '0;
      rst_req_n <= 1'b1;
      busy      <= 1'b0;
      rst_cause <= 2'b00;
      rst_cnt   <= 8'd0;
    end else begin
      state     <= state_nx;
      tmr       <= tmr_nx;
      rst_req_n <= (state_nx != ASSERT);
      busy      <= (state_nx != IDLE);
      if (start_c) begin
        rst_cause <= cause_c;
        if (rst_cnt != 8'hFF) rst_cnt <= rst_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Self-checking bench for rst_req_ctrl: directed scenarios plus random stimulus
// compared every cycle against a countdown-based reference model.
module tb_rst_req_ctrl;

  localparam int A  = 16;
  localparam int C  = 64;
  localparam int W  = 1024;
  localparam int LF = 4;

  logic       src_clk = 1'b0;
  logic       arstn = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       wdt_en = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       pll_locked = 1'b1;
  logic       rst_req_n;
  logic [1:0] rst_cause;
  logic       busy;
  logic [7:0] rst_cnt;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  rst_req_ctrl #(.ASSERT_CYC(A), .COOL_CYC(C), .WDT_CYC(W), .LOCK_FILT(LF)) dut (
    .src_clk(src_clk), .arstn(arstn), .sw_rst_req(sw_rst_req), .wdt_en(wdt_en),
    .wdt_kick(wdt_kick), .pll_locked(pll_locked), .rst_req_n(rst_req_n),
    .rst_cause(rst_cause), .busy(busy), .rst_cnt(rst_cnt)
  );

  always #5 src_clk = ~src_clk;

  // Reference model: one countdown covers the whole event (request + lockout).
  int m_left, m_rel, m_low, m_wcnt, m_cnt, m_cause;
  bit m_p1, m_p2, m_armed, m_pfail, m_pend;
  bit t_run, t_idle, t_wf, t_trig, t_nf;

  always @(posedge src_clk or negedge arstn) begin
    if (!arstn) begin
      m_left = 0; m_rel = 0; m_low = 0; m_wcnt = 0; m_cnt = 0; m_cause = 0;
      m_p1 = 0; m_p2 = 0; m_armed = 0; m_pfail = 0; m_pend = 0;
    end else begin
      t_run  = (m_rel >= 2);
      if (m_rel < 2) m_rel++;
      t_idle = (m_left == 0);
      t_wf   = t_idle && wdt_en && (m_wcnt == W - 1);
      t_trig = t_idle && t_run && (sw_rst_req || m_pend || m_pfail || t_wf);
      if (t_trig) begin
        m_cause = (sw_rst_req || m_pend) ? 1 : (m_pfail ? 2 : 3);
        if (m_cnt < 255) m_cnt++;
      end
      t_nf  = m_armed && !m_p2 && (m_low == LF - 1);
      m_low = (!m_armed || m_p2 || m_low == LF - 1) ? 0 : m_low + 1;
      if (t_trig)    m_armed = 0;
      else if (m_p2) m_armed = 1;
      m_pfail = t_nf;
      m_p2    = m_p1;
      m_p1    = pll_locked;
      m_wcnt  = (!t_idle || !t_run || !wdt_en || wdt_kick || t_wf) ? 0 : m_wcnt + 1;
      if (!t_idle && sw_rst_req) m_pend = 1;
      if (t_trig) m_pend = 0;
      m_left = t_trig ? A + C : (m_left > 0 ? m_left - 1 : 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge src_clk) begin
    if (chk_en) begin
      chk("cmp rst_req_n", int'(rst_req_n), (m_left > C) ? 0 : 1);
      chk("cmp busy",      int'(busy),      (m_left > 0) ? 1 : 0);
      chk("cmp rst_cause", int'(rst_cause), m_cause);
      chk("cmp rst_cnt",   int'(rst_cnt),   m_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge src_clk);
  endtask

  task automatic do_reset();
    #2 arstn = 1'b0;
    tick(2);
    #2 arstn = 1'b1;
    tick(3);
  endtask

  task automatic pulse_sw();
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
  endtask

  int lows, busys;

  initial begin
    tick(3);
    #2 arstn = 1'b1;
    tick(3);
    chk_en = 1;

    chk("reset rst_req_n", int'(rst_req_n), 1);
    chk("reset busy",      int'(busy), 0);
    chk("reset cause",     int'(rst_cause), 0);
    chk("reset cnt",       int'(rst_cnt), 0);

    // Software request: 16 cycles low, 80 busy.
    pulse_sw();
    chk("sw rst_req_n low", int'(rst_req_n), 0);
    chk("sw cause", int'(rst_cause), 1);
    chk("sw cnt", int'(rst_cnt), 1);
    lows = 0; busys = 0;
    for (int i = 0; i < 100; i++) begin
      if (!rst_req_n) lows++;
      if (busy) busys++;
      tick(1);
    end
    chk("sw low cycles", lows, 16);
    chk("sw busy cycles", busys, 80);

    // PLL lock loss: request falls 7 cycles after the drop.
    pll_locked = 1'b0;
    tick(6);
    chk("pll not early", int'(rst_req_n), 1);
    tick(1);
    chk("pll rst_req_n low", int'(rst_req_n), 0);
    chk("pll cause", int'(rst_cause), 2);
    chk("pll cnt", int'(rst_cnt), 2);
    pll_locked = 1'b1;
    tick(100);

    // Three-cycle glitch is filtered out.
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    tick(20);
    chk("glitch cnt", int'(rst_cnt), 2);
    chk("glitch busy", int'(busy), 0);

    // Watchdog expiry at cycle 1024.
    wdt_en = 1'b1;
    tick(1023);
    chk("wdt not early", int'(rst_req_n), 1);
    tick(1);
    chk("wdt rst_req_n low", int'(rst_req_n), 0);
    chk("wdt cause", int'(rst_cause), 3);
    chk("wdt cnt", int'(rst_cnt), 3);
    wdt_en = 1'b0;
    tick(100);

    // Regular kicks keep the watchdog quiet.
    wdt_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(499);
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
    end
    wdt_en = 1'b0;
    chk("kick cnt", int'(rst_cnt), 3);
    chk("kick busy", int'(busy), 0);

    // Request during cool-down is serviced right after it.
    do_reset();
    chk("rst2 cnt", int'(rst_cnt), 0);
    pulse_sw();
    tick(30);
    pulse_sw();
    tick(48);
    chk("pend still busy", int'(busy), 1);
    tick(1);
    chk("pend idle gap busy", int'(busy), 0);
    chk("pend idle gap rst_req_n", int'(rst_req_n), 1);
    tick(1);
    chk("pend second low", int'(rst_req_n), 0);
    chk("pend cnt", int'(rst_cnt), 2);
    tick(100);

    // sw and watchdog on the same cycle: one event, cause sw.
    wdt_en = 1'b1;
    tick(1023);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    wdt_en = 1'b0;
    chk("same cyc cause", int'(rst_cause), 1);
    chk("same cyc cnt", int'(rst_cnt), 3);
    tick(150);
    chk("same cyc single", int'(rst_cnt), 3);

    // Reset during ASSERT releases the request at once.
    pulse_sw();
    tick(4);
    #2 arstn = 1'b0;
    #1;
    chk("arst rst_req_n", int'(rst_req_n), 1);
    chk("arst busy", int'(busy), 0);
    chk("arst cause", int'(rst_cause), 0);
    chk("arst cnt", int'(rst_cnt), 0);
    tick(1);
    #2 arstn = 1'b1;
    tick(3);
    chk("arst no stretch", int'(rst_req_n), 1);

    // Event counter saturates.
    for (int i = 0; i < 256; i++) begin
      pulse_sw();
      tick(85);
    end
    chk("sat cnt", int'(rst_cnt), 255);

    // Random traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      sw_rst_req = ($urandom_range(199) == 0);
      wdt_kick   = ($urandom_range(299) == 0);
      if ($urandom_range(499) == 0) wdt_en = ~wdt_en;
      if ($urandom_range(39) == 0)  pll_locked = ~pll_locked;
      tick(1);
    end
    sw_rst_req = 1'b0;
    wdt_kick = 1'b0;
    tick(2);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
